sync_fifo_ctrl: RTL and testbench
=================================

# sync_fifo_ctrl

Single-clock synchronous FIFO with integrated storage, read/write pointer control, registered status flags and a fill-level counter. It generalises the plain register-file FIFO memory with pointer management, programmable almost-full/almost-empty thresholds and a read-valid strobe. It sits between same-clock producers and consumers, for example between the register-file/ALU command path and the TX serialiser. It is parametrised in data width, depth and threshold levels.

## Interface
- DATA_WIDTH, 8, width of each stored word
- ADDR_WIDTH, 4, pointer width; depth is MEM_DEPTH = 2**ADDR_WIDTH
- AFULL_LVL, 12, ALMOST_FULL asserts when COUNT >= AFULL_LVL; legal range 1..MEM_DEPTH
- AEMPTY_LVL, 2, ALMOST_EMPTY asserts when COUNT <= AEMPTY_LVL; legal range 0..MEM_DEPTH-1

Ports:
- CLK  in  1  single clock; all logic is on the rising edge
- RST  in  1  reset, synchronous, active-high
- WR_EN  in  1  write request
- WR_DATA  in  DATA_WIDTH  write word
- RD_EN  in  1  read request
- RD_DATA  out  DATA_WIDTH  registered read word
- RD_VALID  out  1  one-cycle strobe; RD_DATA holds a newly read word
- FULL  out  1  COUNT == MEM_DEPTH
- EMPTY  out  1  COUNT == 0
- ALMOST_FULL  out  1  COUNT >= AFULL_LVL
- ALMOST_EMPTY  out  1  COUNT <= AEMPTY_LVL
- COUNT  out  ADDR_WIDTH+1  current occupancy, 0..MEM_DEPTH
- OVERFLOW  out  1  sticky error flag; present only with SYNC_FIFO_ERR_EN
- UNDERFLOW  out  1  sticky error flag; present only with SYNC_FIFO_ERR_EN

## Operation
- Storage is a MEM_DEPTH x DATA_WIDTH array. Write pointer wptr and read pointer rptr are ADDR_WIDTH+1 bits wide; the extra MSB is a wrap bit.
- Write accept: wr_acc = WR_EN & ~FULL. On wr_acc, mem[wptr[ADDR_WIDTH-1:0]] <= WR_DATA and wptr increments.
- Read accept: rd_acc = RD_EN & ~EMPTY. On rd_acc, RD_DATA <= mem[rptr[ADDR_WIDTH-1:0]], rptr increments, and RD_VALID is 1 next cycle. Otherwise RD_VALID is 0 and RD_DATA holds its last value.
- Accept decisions use the registered FULL/EMPTY values from the current cycle.
- COUNT update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
- Simultaneous requests when full: the read is accepted and the write is rejected. The write is not deferred.
- Simultaneous requests when empty: the write is accepted and the read is rejected. There is no fall-through.
- Pointers wrap naturally modulo 2**(ADDR_WIDTH+1). FULL/EMPTY come from COUNT, not from pointer comparison.
- All flags are registered from next-state COUNT, so they are exact in the cycle after the change.
- Rejected requests do not change any state, apart from the error flags when SYNC_FIFO_ERR_EN is defined.

## Timing
- Reset (RST=1 at a CLK edge) sets wptr=rptr=0, COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0 (1 if AFULL_LVL==0, which is illegal), RD_DATA=0, RD_VALID=0, OVERFLOW=UNDERFLOW=0.
- Memory contents are not reset.
- RST overrides WR_EN/RD_EN in the same cycle. A reset mid-stream discards all contents.
- Write-to-read latency: a word written at edge N is readable by RD_EN at edge N+1 and appears on RD_DATA after edge N+1.
- Read latency: RD_EN accepted at edge N gives RD_DATA/RD_VALID valid after edge N. RD_VALID lasts one cycle per accepted read. Back-to-back reads give one word per cycle.
- Throughput is one write and one read per cycle sustained.

## Configuration
- SYNC_FIFO_ERR_EN defined: OVERFLOW is set on WR_EN & FULL; UNDERFLOW is set on RD_EN & EMPTY. Each is set the cycle after the event and cleared only by RST.
- SYNC_FIFO_ERR_EN undefined: the OVERFLOW/UNDERFLOW ports and their logic are absent. Rejected requests are silently dropped.

## Test plan
- Reset, then 16 writes of 0x00..0x0F with no reads → COUNT=16 and FULL=1 after the 16th write; ALMOST_FULL=1 from COUNT=12; EMPTY=0.
- Continue from full: 16 reads → RD_DATA sequence 0x00..0x0F with RD_VALID=1 on each; EMPTY=1 after the last; ALMOST_EMPTY=1 from COUNT=2.
- Wrap: write/read 40 words continuously with both enables high → data order preserved across pointer wrap; COUNT constant at its pre-fill value.
- Full with WR_EN=RD_EN=1 and WR_DATA=0xAA → the read returns the oldest word; 0xAA is not stored; COUNT=15. Empty with both enables → the write is stored, RD_VALID=0, COUNT=1.
- With SYNC_FIFO_ERR_EN: write while FULL → OVERFLOW=1 next cycle and sticky; read while EMPTY → UNDERFLOW=1; both return to 0 only after RST.
- Assert RST after 5 writes → COUNT=0, EMPTY=1, RD_VALID=0, RD_DATA=0 next cycle; a following write/read of 0x5A returns 0x5A.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with storage, pointers, registered
// status flags and occupancy count. Optional sticky error flags: SYNC_FIFO_ERR_EN.
//
// Ports:
//   CLK, RST             clock and synchronous active-high reset
//   WR_EN, WR_DATA       write request and word
//   RD_EN                read request
//   RD_DATA, RD_VALID    registered read word and one-cycle valid strobe
//   FULL, EMPTY          COUNT == depth / COUNT == 0
//   ALMOST_FULL/EMPTY    COUNT >= AFULL_LVL / COUNT <= AEMPTY_LVL
//   COUNT                occupancy, 0..depth
//   OVERFLOW, UNDERFLOW  sticky errors (only with SYNC_FIFO_ERR_EN)
module sync_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AFULL_LVL  = 12,
   parameter int AEMPTY_LVL = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WR_EN,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   input  logic                  RD_EN,
   output logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  RD_VALID,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  ALMOST_FULL,
   output logic                  ALMOST_EMPTY,
   output logic [ADDR_WIDTH:0]   COUNT
`ifdef SYNC_FIFO_ERR_EN
   ,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
`endif
);

   localparam int MEM_DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LP_ONE    = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] LP_DEPTH  = (ADDR_WIDTH+1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH:0] LP_AFULL  = (ADDR_WIDTH+1)'(AFULL_LVL);
   localparam logic [ADDR_WIDTH:0] LP_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_LVL);

   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
   logic [ADDR_WIDTH:0]   r_wptr;
   logic [ADDR_WIDTH:0]   r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_valid;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_afull;
   logic                  r_aempty;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [ADDR_WIDTH:0]   w_count_nxt;

   // Accepts use the registered flags, so a full FIFO can still take a
   // write only once a read has actually lowered COUNT.
   assign w_wr_acc = WR_EN & ~r_full;
   assign w_rd_acc = RD_EN & ~r_empty;

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_acc && !w_rd_acc) begin
         w_count_nxt = r_count + LP_ONE;
      end else if (w_rd_acc && !w_wr_acc) begin
         w_count_nxt = r_count - LP_ONE;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge CLK) begin
      if (!RST && w_wr_acc) begin
         r_mem[r_wptr[ADDR_WIDTH-1:0]] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_afull    <= (LP_AFULL == '0);
         r_aempty   <= 1'b1;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_wr_acc) begin
            r_wptr <= r_wptr + LP_ONE;
         end
         if (w_rd_acc) begin
            r_rptr    <= r_rptr + LP_ONE;
            r_rd_data <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
         end
         // Flags come from next-state COUNT so they are exact next cycle.
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == LP_DEPTH);
         r_empty  <= (w_count_nxt == '0);
         r_afull  <= (w_count_nxt >= LP_AFULL);
         r_aempty <= (w_count_nxt <= LP_AEMPTY);
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   logic r_ovf;
   logic r_unf;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (WR_EN && r_full) begin
            r_ovf <= 1'b1;
         end
         if (RD_EN && r_empty) begin
            r_unf <= 1'b1;
         end
      end
   end

   assign OVERFLOW  = r_ovf;
   assign UNDERFLOW = r_unf;
`else
   // Rejected requests are dropped with no record.
`endif

   assign RD_DATA      = r_rd_data;
   assign RD_VALID     = r_rd_valid;
   assign FULL         = r_full;
   assign EMPTY        = r_empty;
   assign ALMOST_FULL  = r_afull;
   assign ALMOST_EMPTY = r_aempty;
   assign COUNT        = r_count;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed and random stimulus for sync_fifo_ctrl,
// checked every cycle against a queue-based occupancy/data model.
module tb_sync_fifo_ctrl;

   localparam int DEPTH = 16;
   localparam int AFL   = 12;
   localparam int AEL   = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       afull;
   logic       aempty;
   logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
   logic       ovf;
   logic       unf;
`endif

   sync_fifo_ctrl dut (
      .CLK          (clk),
      .RST          (rst),
      .WR_EN        (wr_en),
      .WR_DATA      (wr_data),
      .RD_EN        (rd_en),
      .RD_DATA      (rd_data),
      .RD_VALID     (rd_valid),
      .FULL         (full),
      .EMPTY        (empty),
      .ALMOST_FULL  (afull),
      .ALMOST_EMPTY (aempty),
      .COUNT        (count)
`ifdef SYNC_FIFO_ERR_EN
      ,
      .OVERFLOW     (ovf),
      .UNDERFLOW    (unf)
`endif
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] q [$];
   logic [7:0] m_data = '0;
   logic       m_valid = 1'b0;
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive, update model at the edge, sample 1 time unit later.
   task automatic step(input bit r, input bit w, input logic [7:0] d,
                       input bit rd);
      int sz;
      bit wacc;
      bit racc;
      rst     = r;
      wr_en   = w;
      wr_data = d;
      rd_en   = rd;
      @(posedge clk);
      sz = q.size();
      if (r) begin
         q.delete();
         m_data  = '0;
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
      end else begin
         wacc = w && (sz < DEPTH);
         racc = rd && (sz > 0);
         if (w && sz == DEPTH) m_ovf = 1'b1;
         if (rd && sz == 0) m_unf = 1'b1;
         m_valid = racc;
         if (racc) m_data = q.pop_front();
         if (wacc) q.push_back(d);
      end
      #1;
      sz = q.size();
      chk("rd_valid", 32'(rd_valid), 32'(m_valid));
      chk("rd_data", 32'(rd_data), 32'(m_data));
      chk("count", 32'(count), 32'(sz));
      chk("full", 32'(full), 32'(sz == DEPTH));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("almost_full", 32'(afull), 32'(sz >= AFL));
      chk("almost_empty", 32'(aempty), 32'(sz <= AEL));
`ifdef SYNC_FIFO_ERR_EN
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("underflow", 32'(unf), 32'(m_unf));
`endif
   endtask

   initial begin
      int c0;
      // Reset.
      step(1, 0, 8'h00, 0);
      step(1, 1, 8'h33, 1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      // Fill 0x00..0x0F.
      for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd16);
      // Drain in order.
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 8'h00, 1);
         chk("drain_word", 32'(rd_data), 32'(i));
      end
      chk("drain_empty", 32'(empty), 32'd1);
      // Read on empty.
      step(0, 0, 8'h00, 1);
      // Pre-fill 5 then stream 40 through across the pointer wrap.
      for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0);
      for (int i = 0; i < 40; i++) begin
         step(0, 1, 8'($urandom), 1);
         chk("wrap_count", 32'(count), 32'd5);
      end
      // Fill, then both enables while full with 0xAA.
      while (q.size() < DEPTH) step(0, 1, 8'($urandom), 0);
      c0 = 32'(q[0]);
      step(0, 1, 8'hAA, 1);
      chk("full_both_oldest", 32'(rd_data), 32'(c0));
      chk("full_both_count", 32'(count), 32'd15);
      step(0, 1, 8'h11, 0);
      step(0, 1, 8'h22, 0);
      // Drain; the 0xAA must never appear.
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 8'h00, 1);
         assert (!(rd_valid && rd_data == 8'hAA && i < 14)) else begin
            n_err++;
            $error("FAIL aa_stored observed=%0h expected=not_aa", rd_data);
         end
         n_cmp++;
      end
      // Both enables while empty.
      step(0, 1, 8'h77, 1);
      chk("empty_both_valid", 32'(rd_valid), 32'd0);
      chk("empty_both_count", 32'(count), 32'd1);
      step(0, 0, 8'h00, 1);
      chk("empty_both_word", 32'(rd_data), 32'h77);
      // Sticky error flags then cleared by reset.
      step(0, 0, 8'h00, 1);
      for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 8'(i), 0);
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);
      // Random traffic with drifting bias.
      for (int i = 0; i < 3000; i++) begin
         int bias;
         bias = (i / 300) % 3;
         step(($urandom_range(0, 499) == 0),
              ($urandom_range(0, 3) < 1 + bias),
              8'($urandom),
              ($urandom_range(0, 3) < 3 - bias));
      end
      // Reset mid-stream after 5 writes.
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 8'(i + 1), 0);
      step(1, 1, 8'h99, 1);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_data", 32'(rd_data), 32'd0);
      chk("midrst_valid", 32'(rd_valid), 32'd0);
      step(0, 1, 8'h5A, 0);
      step(0, 0, 8'h00, 1);
      chk("post_rst_word", 32'(rd_data), 32'h5A);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
